// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One cycle's worth of datapath control strobes.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       load_half;
        logic       load_half_unsigned;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles in a memory state and flags a timeout.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait_i,
    input  logic state_change_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              clear_c;

    assign timeout_o = (MAX_WAIT != 0) && in_wait_i && !mem_ready_i && (wait_cnt_q == LIMIT);

    // A timeout re-enters FETCH from FETCH, so it must clear the count as well.
    assign clear_c = state_change_i || !in_wait_i || mem_ready_i || timeout_o;

    always_comb begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (clear_c) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM sequencing a shared-memory multi-cycle MIPS datapath.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             load_half,
    output logic             load_half_unsigned,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    state_e             state_q, state_d;
    logic [5:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    ctrl_t              ctrl_c;
    logic               retire_c;
    logic               timeout_c;
    logic               is_half_c;

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk            (clk),
        .rst            (rst),
        .in_wait_i      (is_wait_state(state_q)),
        .state_change_i (state_d != state_q),
        .mem_ready_i    (mem_ready),
        .timeout_o      (timeout_c)
    );

    assign is_half_c = (op_q == OP_LH) || (op_q == OP_LHU);

    // Next-state and Moore outputs; FETCH strobes and DECODE illegal_op are Mealy.
    always_comb begin
        ctrl_c   = '0;
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end else if (timeout_c) begin
                    ctrl_c.mem_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                ctrl_c.alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                       state_d = S_R_EXEC;
                    OP_LW, OP_LH, OP_LHU, OP_SW:    state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:                 state_d = S_BRANCH;
                    OP_J:                           state_d = S_JUMP;
                    default: begin
                        ctrl_c.illegal_op = 1'b1;
                        state_d           = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
                state_d          = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl_c.mem_read           = 1'b1;
                ctrl_c.i_or_d             = 1'b1;
                ctrl_c.load_half          = is_half_c;
                ctrl_c.load_half_unsigned = (op_q == OP_LHU);
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_c) begin
                    ctrl_c.mem_timeout = 1'b1;
                    state_d            = S_FETCH;
                end
            end
            S_MEM_WB: begin
                ctrl_c.reg_write          = 1'b1;
                ctrl_c.mem_to_reg         = 1'b1;
                ctrl_c.load_half          = is_half_c;
                ctrl_c.load_half_unsigned = (op_q == OP_LHU);
                state_d                   = S_FETCH;
                retire_c                  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end else if (timeout_c) begin
                    ctrl_c.mem_timeout = 1'b1;
                    state_d            = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_B;
                ctrl_c.alu_op    = ALU_FUNCT;
                state_d          = S_R_WB;
            end
            S_R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                state_d          = S_FETCH;
                retire_c         = 1'b1;
            end
            S_I_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                case (op_q)
                    OP_ANDI: ctrl_c.alu_op = ALU_AND;
                    OP_ORI:  ctrl_c.alu_op = ALU_OR;
                    OP_SLTI: ctrl_c.alu_op = ALU_SLT;
                    default: ctrl_c.alu_op = ALU_ADD;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                ctrl_c.reg_write = 1'b1;
                state_d          = S_FETCH;
                retire_c         = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_src_b     = SRCB_B;
                ctrl_c.alu_op        = ALU_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
                ctrl_c.branch_ne     = (op_q == OP_BNE);
                state_d              = S_FETCH;
                retire_c             = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                state_d          = S_FETCH;
                retire_c         = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            ctrl_c   = '0;
            retire_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (retire_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_write           = ctrl_c.pc_write;
    assign pc_write_cond      = ctrl_c.pc_write_cond;
    assign branch_ne          = ctrl_c.branch_ne;
    assign pc_source          = ctrl_c.pc_source;
    assign i_or_d             = ctrl_c.i_or_d;
    assign mem_read           = ctrl_c.mem_read;
    assign mem_write          = ctrl_c.mem_write;
    assign ir_write           = ctrl_c.ir_write;
    assign mem_to_reg         = ctrl_c.mem_to_reg;
    assign reg_dst            = ctrl_c.reg_dst;
    assign reg_write          = ctrl_c.reg_write;
    assign alu_src_a          = ctrl_c.alu_src_a;
    assign alu_src_b          = ctrl_c.alu_src_b;
    assign alu_op             = ctrl_c.alu_op;
    assign load_half          = ctrl_c.load_half;
    assign load_half_unsigned = ctrl_c.load_half_unsigned;
    assign illegal_op         = ctrl_c.illegal_op;
    assign mem_timeout        = ctrl_c.mem_timeout;
    assign state_out          = state_q;
    assign instr_count        = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a random instruction stream.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, load_half, load_half_unsigned;
    logic        illegal_op, mem_timeout;
    logic [1:0]  pc_source, alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state_out;
    logic [31:0] instr_count;

    int checks = 0;
    int passes = 0;
    int exp_cnt = 0;

    logic [5:0] legal [12] = '{6'h00, 6'h23, 6'h21, 6'h25, 6'h2b, 6'h08,
                               6'h0c, 6'h0d, 6'h0a, 6'h04, 6'h05, 6'h02};

    multicycle_control #(.MAX_WAIT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .load_half(load_half),
        .load_half_unsigned(load_half_unsigned), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_out(state_out), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] strobes();
        return {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                load_half, load_half_unsigned, illegal_op, mem_timeout};
    endfunction

    // Drive one cycle's inputs on the falling edge and let outputs settle.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic r);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        rst       = r;
        #1;
    endtask

    task automatic test_reset();
        cyc(6'h23, 1'b1, 1'b1);
        checks++; if (strobes() !== 22'd0) $display("FAIL reset_strobes1: got %h want 0", strobes()); else passes++;
        checks++; if (state_out !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_out); else passes++;
        checks++; if (instr_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", instr_count); else passes++;
        cyc(6'h23, 1'b1, 1'b1);
        checks++; if (strobes() !== 22'd0) $display("FAIL reset_strobes2: got %h want 0", strobes()); else passes++;
        exp_cnt = 0;
    endtask

    task automatic test_lw();
        cyc(6'h23, 1'b1, 1'b0);
        checks++; if (state_out !== 4'd0) $display("FAIL lw_s0: got %0d want 0", state_out); else passes++;
        checks++; if ({ir_write, pc_write, mem_read, i_or_d, alu_src_b} !== 6'b111001)
            $display("FAIL lw_fetch_ctl: got %b want 111001", {ir_write, pc_write, mem_read, i_or_d, alu_src_b}); else passes++;
        cyc(6'h23, 1'b1, 1'b0);
        checks++; if ({state_out, alu_src_b} !== {4'd1, 2'b11}) $display("FAIL lw_decode: got %0d/%b want 1/11", state_out, alu_src_b); else passes++;
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, alu_src_a, alu_src_b} !== {4'd2, 1'b1, 2'b10}) $display("FAIL lw_addr: got %0d/%b/%b want 2/1/10", state_out, alu_src_a, alu_src_b); else passes++;
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, mem_read, i_or_d, load_half} !== {4'd3, 3'b110}) $display("FAIL lw_memrd: got %0d/%b want 3/110", state_out, {mem_read, i_or_d, load_half}); else passes++;
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, reg_write, mem_to_reg, reg_dst} !== {4'd4, 3'b110}) $display("FAIL lw_memwb: got %0d/%b want 4/110", state_out, {reg_write, mem_to_reg, reg_dst}); else passes++;
        exp_cnt++;
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, instr_count} !== {4'd0, 32'(exp_cnt)}) $display("FAIL lw_retire: got %0d/%0d want 0/%0d", state_out, instr_count, exp_cnt); else passes++;
    endtask

    task automatic test_rtype();
        cyc(6'h00, 1'b1, 1'b0);
        cyc(6'h00, 1'b1, 1'b0);
        checks++; if (state_out !== 4'd1) $display("FAIL r_decode: got %0d want 1", state_out); else passes++;
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, alu_op, alu_src_a, alu_src_b} !== {4'd6, 3'b010, 1'b1, 2'b00}) $display("FAIL r_exec: got %0d/%b/%b/%b", state_out, alu_op, alu_src_a, alu_src_b); else passes++;
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, reg_write, reg_dst, mem_to_reg} !== {4'd7, 3'b110}) $display("FAIL r_wb: got %0d/%b want 7/110", state_out, {reg_write, reg_dst, mem_to_reg}); else passes++;
        exp_cnt++;
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, instr_count} !== {4'd0, 32'(exp_cnt)}) $display("FAIL r_retire: got %0d/%0d want 0/%0d", state_out, instr_count, exp_cnt); else passes++;
    endtask

    task automatic test_branch();
        logic [5:0] ops [2];
        ops[0] = 6'h05;
        ops[1] = 6'h04;
        for (int i = 0; i < 2; i++) begin
            cyc(ops[i], 1'b1, 1'b0);
            cyc(ops[i], 1'b1, 1'b0);
            cyc(6'h3f, 1'b1, 1'b0);
            checks++;
            if ({state_out, pc_write_cond, branch_ne, alu_op, pc_source, pc_write} !== {4'd10, 1'b1, (i == 0), 3'b001, 2'b01, 1'b0})
                $display("FAIL branch_%0d: got %0d/%b/%b/%b/%b/%b", i, state_out, pc_write_cond, branch_ne, alu_op, pc_source, pc_write);
            else passes++;
            exp_cnt++;
            cyc(6'h00, 1'b0, 1'b0);
            checks++; if ({state_out, instr_count} !== {4'd0, 32'(exp_cnt)}) $display("FAIL branch_retire_%0d: got %0d/%0d want 0/%0d", i, state_out, instr_count, exp_cnt); else passes++;
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 5; k++) begin
            cyc(6'h02, 1'b0, 1'b0);
            checks++; if ({state_out, ir_write, pc_write, mem_read} !== {4'd0, 3'b001}) $display("FAIL stall_%0d: got %0d/%b want 0/001", k, state_out, {ir_write, pc_write, mem_read}); else passes++;
        end
        cyc(6'h02, 1'b1, 1'b0);
        checks++; if ({state_out, ir_write, pc_write} !== {4'd0, 2'b11}) $display("FAIL stall_release: got %0d/%b want 0/11", state_out, {ir_write, pc_write}); else passes++;
        cyc(6'h02, 1'b1, 1'b0);
        checks++; if ({state_out, ir_write, pc_write} !== {4'd1, 2'b00}) $display("FAIL stall_decode: got %0d/%b want 1/00", state_out, {ir_write, pc_write}); else passes++;
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, pc_write, pc_source} !== {4'd11, 1'b1, 2'b10}) $display("FAIL jump: got %0d/%b/%b want 11/1/10", state_out, pc_write, pc_source); else passes++;
        exp_cnt++;
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, instr_count} !== {4'd0, 32'(exp_cnt)}) $display("FAIL jump_retire: got %0d/%0d want 0/%0d", state_out, instr_count, exp_cnt); else passes++;
    endtask

    task automatic test_timeout();
        cyc(6'h2b, 1'b1, 1'b0);
        cyc(6'h2b, 1'b1, 1'b0);
        cyc(6'h00, 1'b1, 1'b0);
        checks++; if (state_out !== 4'd2) $display("FAIL sw_addr: got %0d want 2", state_out); else passes++;
        for (int k = 1; k <= 16; k++) begin
            cyc(6'h00, 1'b0, 1'b0);
            checks++;
            if ({state_out, mem_write, i_or_d, mem_timeout} !== {4'd5, 2'b11, (k == 16)})
                $display("FAIL sw_wait_%0d: got %0d/%b/%b want 5/11/%0d", k, state_out, {mem_write, i_or_d}, mem_timeout, (k == 16));
            else passes++;
        end
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, mem_timeout, instr_count} !== {4'd0, 1'b0, 32'(exp_cnt)}) $display("FAIL timeout_after: got %0d/%b/%0d want 0/0/%0d", state_out, mem_timeout, instr_count, exp_cnt); else passes++;
    endtask

    task automatic test_illegal();
        cyc(6'h3f, 1'b1, 1'b0);
        cyc(6'h3f, 1'b1, 1'b0);
        checks++; if ({state_out, illegal_op} !== {4'd1, 1'b1}) $display("FAIL illegal_decode: got %0d/%b want 1/1", state_out, illegal_op); else passes++;
        cyc(6'h3f, 1'b0, 1'b0);
        checks++; if ({state_out, illegal_op, instr_count} !== {4'd0, 1'b0, 32'(exp_cnt)}) $display("FAIL illegal_after: got %0d/%b/%0d want 0/0/%0d", state_out, illegal_op, instr_count, exp_cnt); else passes++;
    endtask

    task automatic test_reset_mid();
        cyc(6'h25, 1'b1, 1'b0);
        cyc(6'h25, 1'b1, 1'b0);
        cyc(6'h00, 1'b1, 1'b0);
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, mem_read, load_half, load_half_unsigned} !== {4'd3, 3'b111}) $display("FAIL lhu_memrd: got %0d/%b want 3/111", state_out, {mem_read, load_half, load_half_unsigned}); else passes++;
        cyc(6'h00, 1'b1, 1'b1);
        checks++; if ({state_out, strobes()} !== {4'd3, 22'd0}) $display("FAIL midreset_strobes: got %0d/%h want 3/0", state_out, strobes()); else passes++;
        exp_cnt = 0;
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, instr_count} !== {4'd0, 32'(exp_cnt)}) $display("FAIL midreset_after: got %0d/%0d want 0/%0d", state_out, instr_count, exp_cnt); else passes++;
    endtask

    // Random instruction stream checked against an instruction-class path model.
    task automatic test_random();
        int          path [$];
        logic [5:0]  op;
        logic [5:0]  drv;
        int          st;
        bit          illegal;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else op = legal[$urandom_range(0, 11)];
            case (op)
                6'h00:                      path = {0, 1, 6, 7};
                6'h23, 6'h21, 6'h25:        path = {0, 1, 2, 3, 4};
                6'h2b:                      path = {0, 1, 2, 5};
                6'h08, 6'h0c, 6'h0d, 6'h0a: path = {0, 1, 8, 9};
                6'h04, 6'h05:               path = {0, 1, 10};
                6'h02:                      path = {0, 1, 11};
                default:                    path = {0, 1};
            endcase
            illegal = (path.size() == 2);
            for (int j = 0; j < path.size(); j++) begin
                st  = path[j];
                drv = (st <= 1) ? op : 6'($urandom);
                if (st == 0 || st == 3 || st == 5) begin
                    repeat ($urandom_range(0, 3)) begin
                        cyc(drv, 1'b0, 1'b0);
                        checks++; if (state_out !== 4'(st)) $display("FAIL rnd_stall n=%0d op=%h: got %0d want %0d", n, op, state_out, st); else passes++;
                    end
                    cyc(drv, 1'b1, 1'b0);
                end else begin
                    cyc(drv, 1'($urandom), 1'b0);
                end
                checks++; if (state_out !== 4'(st)) $display("FAIL rnd_state n=%0d op=%h: got %0d want %0d", n, op, state_out, st); else passes++;
                checks++;
                if ({reg_write, mem_write} !== {(st == 4 || st == 7 || st == 9), (st == 5)})
                    $display("FAIL rnd_wr n=%0d st=%0d: got %b", n, st, {reg_write, mem_write});
                else passes++;
                if (st == 0) begin
                    checks++; if (instr_count !== 32'(exp_cnt)) $display("FAIL rnd_count n=%0d: got %0d want %0d", n, instr_count, exp_cnt); else passes++;
                end
                if (st == 1) begin
                    checks++; if (illegal_op !== illegal) $display("FAIL rnd_illegal n=%0d op=%h: got %b want %b", n, op, illegal_op, illegal); else passes++;
                end
            end
            if (!illegal) exp_cnt++;
        end
        cyc(6'h00, 1'b0, 1'b0);
        checks++; if ({state_out, instr_count} !== {4'd0, 32'(exp_cnt)}) $display("FAIL rnd_final: got %0d/%0d want 0/%0d", state_out, instr_count, exp_cnt); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_stall();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM (with documented Mealy exceptions) that sequences a shared-memory, multi-cycle MIPS datapath built from the existing ALU, RegisterFile, ALUControl and mux blocks.
- Per instruction it steps through fetch, decode, execute, memory and write-back, driving one set of control strobes per cycle.
- Stalls on a memory ready handshake, with timeout protection.
- Reports the retired-instruction count and error flags.

Parameters:
- MAX_WAIT, 16: maximum cycles in any memory state before timeout; 0 disables the timeout.
- CNT_W, 32: width of instr_count.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- opcode, input, 6: instruction register bits [31:26].
- mem_ready, input, 1: memory has completed the current read or write this cycle.
- pc_write, output, 1: unconditional PC load.
- pc_write_cond, output, 1: PC load if the branch condition holds.
- branch_ne, output, 1: condition polarity; 0 = beq (zero), 1 = bne (!zero).
- pc_source, output, 2: 00 ALU result, 01 ALUOut register, 10 jump target.
- i_or_d, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- mem_read, output, 1: memory read request.
- mem_write, output, 1: memory write request.
- ir_write, output, 1: instruction register load.
- mem_to_reg, output, 1: write-back data select; 1 = memory data register.
- reg_dst, output, 1: destination select; 1 = rd, 0 = rt.
- reg_write, output, 1: register file write enable.
- alu_src_a, output, 1: 0 = PC, 1 = register A.
- alu_src_b, output, 2: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- alu_op, output, 3: ALU operation code fed to ALUControl.
- load_half, output, 1: halfword load.
- load_half_unsigned, output, 1: unsigned halfword load.
- illegal_op, output, 1: one-cycle pulse on an unknown opcode.
- mem_timeout, output, 1: one-cycle pulse on memory timeout.
- state_out, output, 4: current state encoding, for debug.
- instr_count, output, CNT_W: number of retired instructions.

Behaviour:
- Reset:
  - On a rst-high edge: state = FETCH, instr_count = 0, wait_cnt = 0.
  - While rst is high, every output except state_out and instr_count is forced to 0.
- States, in order 0..11: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD.
  - ir_write and pc_write equal mem_ready (Mealy).
  - mem_ready = 1 → DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = ADD (precomputes the branch target).
  - Dispatch on opcode:
    - 000000 → R_EXEC
    - lw 100011, lh 100001, lhu 100101, sw 101011 → MEM_ADDR
    - addi 001000, andi 001100, ori 001101, slti 001010 → I_EXEC
    - beq 000100, bne 000101 → BRANCH
    - j 000010 → JUMP
    - any other opcode → FETCH with illegal_op = 1; not counted as retired.
- MEM_ADDR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = ADD.
  - sw → MEM_WR; all loads → MEM_RD.
- MEM_RD:
  - Outputs: mem_read = 1, i_or_d = 1.
  - load_half = 1 for lh/lhu; load_half_unsigned = 1 for lhu.
  - mem_ready → MEM_WB.
- MEM_WB:
  - Outputs: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
  - Same halfword flags as MEM_RD.
  - → FETCH, retire.
- MEM_WR:
  - Outputs: mem_write = 1, i_or_d = 1.
  - mem_ready → FETCH, retire.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = FUNCT; → R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; → FETCH, retire.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = ADD / AND / OR / SLT by opcode; → I_WB.
- I_WB: reg_write = 1, reg_dst = 0; → FETCH, retire.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_write_cond = 1, pc_source = 01.
  - branch_ne = 1 for bne.
  - → FETCH, retire.
- JUMP: pc_write = 1, pc_source = 10; → FETCH, retire.
- Opcode latch: the opcode is latched into an internal register at the end of DECODE. Later states use the latched copy; the opcode port is ignored after DECODE.
- Memory wait and timeout:
  - wait_cnt counts consecutive cycles in FETCH, MEM_RD or MEM_WR without mem_ready, and clears on any state change.
  - If MAX_WAIT != 0 and wait_cnt == MAX_WAIT - 1 with mem_ready = 0:
    - mem_timeout pulses for one cycle and the next state is FETCH.
    - In FETCH, ir_write and pc_write stay 0.
    - The instruction is not retired.
  - When mem_ready and timeout coincide on the same cycle, mem_ready wins.
- Retirement: instr_count += 1 on every retiring transition listed above; it wraps modulo 2^CNT_W.
- Reset mid-instruction aborts the instruction with no retire; the next cycle after rst falls is FETCH.
- Unused control outputs are 0 in every state (no don't-cares).

Decomposition:
- Package mc_pkg:
  - State enum (4-bit, values 0..11).
  - Opcode constants.
  - alu_op constants: ADD = 000, SUB = 001, FUNCT = 010, AND = 011, OR = 100, SLT = 101.
  - alu_src_b and pc_source encodings.
- Sub-module mc_wait_timer: wait_cnt, clear on state change, timeout compare. The FSM and output decode stay in the top module.

Test Plan:
- rst high for 2 cycles, then lw with mem_ready immediate → states 0,1,2,3,4,0 over 5 cycles; reg_write = 1 and mem_to_reg = 1 in MEM_WB; instr_count = 1.
- R-type (opcode 000000), mem_ready = 1 → states FETCH, DECODE, R_EXEC (alu_op = 010), R_WB (reg_dst = 1); 4 cycles total.
- bne in DECODE → BRANCH with pc_write_cond = 1, branch_ne = 1, alu_op = 001, pc_source = 01. Same test with beq → branch_ne = 0.
- Memory stall: hold mem_ready = 0 for 5 cycles in FETCH with MAX_WAIT = 16 → state stays 0 and ir_write = 0 throughout; on mem_ready = 1, ir_write = pc_write = 1 for exactly that cycle.
- Timeout: mem_ready held 0 during sw MEM_WR, MAX_WAIT = 16 → mem_timeout pulses on the 16th cycle in MEM_WR, next state FETCH, instr_count unchanged.
- Illegal opcode 111111 → illegal_op = 1 for one cycle in DECODE, next state FETCH, instr_count unchanged. Asserting rst during MEM_RD → next state FETCH, all strobes 0 during reset.
